// File: rtl/fj_ctrl_pkg.sv
// Shared types and limits for the fork-join dispatcher.
package fj_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, FORK, JOIN, RESP} fj_state_e;

  localparam int FJ_MAX_SLV = 16;

endpackage

// File: rtl/fj_watchdog.sv
// Cycle watchdog for the join phase: counts while enabled, flags when TO_CYC is reached.
module fj_watchdog #(
  parameter int TO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int WDW = (TO_CYC < 1) ? 1 : $clog2(TO_CYC + 1);

  logic [WDW-1:0] wd_cnt;

  assign expired = (wd_cnt == WDW'(TO_CYC));

  // Saturates at the limit so expired stays asserted until the next clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wd_cnt <= '0;
    end else if (en && !expired) begin
      wd_cnt <= wd_cnt + WDW'(1);
    end
  end

endmodule

// File: rtl/fj_dispatch_ctrl.sv
// Fork-join dispatcher: broadcasts a master request to all enabled slaves and acks after all complete.
// Optional join watchdog enabled by defining FJ_TIMEOUT_EN.
module fj_dispatch_ctrl
  import fj_ctrl_pkg::*;
#(
  parameter int NSLV   = 2,
  parameter int AW     = 8,
  parameter int TO_CYC = 255,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_req,
  input  logic [AW-1:0]   m_addr,
  output logic            m_ack,
  output logic            m_err,
  input  logic [NSLV-1:0] s_en_mask,
  output logic [NSLV-1:0] s_start,
  output logic [AW-1:0]   s_addr,
  input  logic [NSLV-1:0] s_done,
  output logic            busy,
  output logic [CNTW-1:0] txn_cnt
);

  if (NSLV < 1 || NSLV > FJ_MAX_SLV || TO_CYC < 1) begin : g_param_check
    $error("fj_dispatch_ctrl: NSLV must be 1..16 and TO_CYC at least 1");
  end

  fj_state_e       state;
  logic [NSLV-1:0] pending;
  logic [NSLV-1:0] pending_nxt;
  logic            wd_expired;

  // s_done is applied in FORK and JOIN alike; bits not pending simply stay clear.
  assign pending_nxt = pending & ~s_done;
  assign busy        = (state != IDLE);

`ifdef FJ_TIMEOUT_EN
  logic fork_go;
  logic m_err_q;

  assign fork_go = (state == IDLE) && m_req && (s_en_mask != '0);
  assign m_err   = m_err_q;

  fj_watchdog #(
    .TO_CYC (TO_CYC)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (fork_go),
    .en      (state == JOIN),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
  assign m_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      s_start <= '0;
      s_addr  <= '0;
      m_ack   <= 1'b0;
      txn_cnt <= '0;
`ifdef FJ_TIMEOUT_EN
      m_err_q <= 1'b0;
`endif
    end else begin
      s_start <= '0;
      m_ack   <= 1'b0;
`ifdef FJ_TIMEOUT_EN
      m_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (m_req) begin
            s_addr  <= m_addr;
            pending <= s_en_mask;
            if (s_en_mask != '0) begin
              state   <= FORK;
              s_start <= s_en_mask;
            end else begin
              state <= RESP;
              m_ack <= 1'b1;
            end
          end
        end
        FORK: begin
          pending <= pending_nxt;
          state   <= JOIN;
        end
        // A completion arriving in the expiry cycle still wins over the abort.
        JOIN: begin
          if (pending_nxt == '0) begin
            pending <= '0;
            state   <= RESP;
            m_ack   <= 1'b1;
          end else if (wd_expired) begin
            pending <= '0;
            state   <= RESP;
            m_ack   <= 1'b1;
`ifdef FJ_TIMEOUT_EN
            m_err_q <= 1'b1;
`endif
          end else begin
            pending <= pending_nxt;
          end
        end
        RESP: begin
          txn_cnt <= txn_cnt + CNTW'(1);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fj_dispatch_ctrl.sv
// Scoreboard bench for fj_dispatch_ctrl; watchdog scenario runs when FJ_TIMEOUT_EN is defined.
module tb_fj_dispatch_ctrl;

  localparam int NSLV = 2;
  localparam int AW   = 8;
  localparam int TO   = 8;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_req;
  logic [AW-1:0]   m_addr;
  logic            m_ack;
  logic            m_err;
  logic [NSLV-1:0] s_en_mask;
  logic [NSLV-1:0] s_start;
  logic [AW-1:0]   s_addr;
  logic [NSLV-1:0] s_done;
  logic            busy;
  logic [CNTW-1:0] txn_cnt;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [CNTW-1:0] exp_txn;

  typedef struct {
    logic [NSLV-1:0] mask;
    logic [AW-1:0]   addr;
    int              cyc;
  } start_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          err;
    int            cyc;
  } ack_t;

  start_t start_q[$];
  ack_t   ack_q[$];
  start_t se;
  ack_t   ae;

  fj_dispatch_ctrl #(
    .NSLV   (NSLV),
    .AW     (AW),
    .TO_CYC (TO),
    .CNTW   (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .s_en_mask (s_en_mask),
    .s_start   (s_start),
    .s_addr    (s_addr),
    .s_done    (s_done),
    .busy      (busy),
    .txn_cnt   (txn_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference join: returns the ack cycle relative to the request cycle and the error flag.
  task automatic model(input logic [NSLV-1:0] mask, input int d0, input int d1,
                       output int ack_rel, output logic err);
    logic [NSLV-1:0] pend;
    logic [NSLV-1:0] dn;
    pend    = mask;
    err     = 1'b0;
    ack_rel = -1;
    if (mask == '0) begin
      ack_rel = 1;
      return;
    end
    dn   = {(d1 == 1), (d0 == 1)};
    pend = pend & ~dn;
    for (int k = 2; k < 100; k++) begin
      dn = {(d1 == k), (d0 == k)};
      if ((pend & ~dn) == '0) begin
        ack_rel = k + 1;
        return;
      end
`ifdef FJ_TIMEOUT_EN
      if (k - 2 == TO) begin
        ack_rel = k + 1;
        err     = 1'b1;
        return;
      end
`endif
      pend = pend & ~dn;
    end
  endtask

  // Monitor: every fork and every ack must match the next scoreboard entry.
  always @(negedge clk) begin
    if ((|s_start) === 1'b1) begin
      if (start_q.size() == 0) begin
        checkOutput("unexpected_start", 32'(s_start), 32'd0);
      end else begin
        se = start_q.pop_front();
        checkOutput("start_mask", 32'(s_start), 32'(se.mask));
        checkOutput("start_addr", 32'(s_addr), 32'(se.addr));
        checkOutput("start_cycle", cycle, se.cyc);
      end
    end
    if (m_ack === 1'b1) begin
      if (ack_q.size() == 0) begin
        checkOutput("unexpected_ack", 32'd1, 32'd0);
      end else begin
        ae = ack_q.pop_front();
        checkOutput("ack_err", 32'(m_err), 32'(ae.err));
        checkOutput("ack_addr", 32'(s_addr), 32'(ae.addr));
        checkOutput("ack_cycle", cycle, ae.cyc);
      end
    end else if (m_err === 1'b1) begin
      checkOutput("err_without_ack", 32'd1, 32'd0);
    end
  end

  // Entered in an IDLE cycle; leaves after checking the following IDLE cycle.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [NSLV-1:0] mask,
                               input int d0, input int d1, input bit hold, input bit flip_mask);
    int   c0;
    int   ack_rel;
    logic err;
    model(mask, d0, d1, ack_rel, err);
    m_req     = 1'b1;
    m_addr    = addr;
    s_en_mask = mask;
    s_done    = '0;
    c0        = cycle;
    if (mask != '0) start_q.push_back('{mask, addr, c0 + 1});
    ack_q.push_back('{addr, err, c0 + ack_rel});
    for (int k = 1; k <= ack_rel; k++) begin
      tick();
      s_done = {(d1 == k), (d0 == k)};
      if (flip_mask && k == 2) begin
        s_en_mask = ~mask;
        m_addr    = ~addr;
      end
      if (k == ack_rel) begin
        if (!hold) m_req = 1'b0;
        @(negedge clk);
        checkOutput("ack_seen", 32'(m_ack), 32'd1);
        checkOutput("busy_in_ack", 32'(busy), 32'd1);
      end
    end
    exp_txn = exp_txn + CNTW'(1);
    tick();
    s_done = '0;
    @(negedge clk);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("txn_cnt", 32'(txn_cnt), 32'(exp_txn));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst       = 1'b1;
    m_req     = 1'b1;
    m_addr    = 8'h3C;
    s_en_mask = 2'b11;
    s_done    = '0;
    exp_txn   = '0;

    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      checkOutput("rst_start", 32'(s_start), 32'd0);
      checkOutput("rst_ack", 32'(m_ack), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_txn", 32'(txn_cnt), 32'd0);
      checkOutput("rst_saddr", 32'(s_addr), 32'd0);
    end
    rst   = 1'b0;
    m_req = 1'b0;
    tick();

    applyStimulus(8'hA5, 2'b11, 2, 5, 1'b0, 1'b0);
    applyStimulus(8'h5A, 2'b10, 2, 4, 1'b0, 1'b0);
    applyStimulus(8'h77, 2'b00, -1, -1, 1'b0, 1'b0);
    applyStimulus(8'h11, 2'b01, 1, -1, 1'b0, 1'b0);
    applyStimulus(8'h22, 2'b11, 1, 1, 1'b1, 1'b0);
    applyStimulus(8'h33, 2'b11, 3, 2, 1'b0, 1'b0);
    applyStimulus(8'h44, 2'b01, 6, -1, 1'b0, 1'b1);

    // Reset while the join is still waiting on slave 1.
    m_req     = 1'b1;
    m_addr    = 8'h99;
    s_en_mask = 2'b11;
    start_q.push_back('{2'b11, 8'h99, cycle + 1});
    tick();
    m_req = 1'b0;
    tick();
    rst    = 1'b1;
    s_done = 2'b01;
    tick();
    rst     = 1'b0;
    s_done  = '0;
    exp_txn = '0;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_txn", 32'(txn_cnt), 32'd0);
    checkOutput("midrst_saddr", 32'(s_addr), 32'd0);
    checkOutput("midrst_ack", 32'(m_ack), 32'd0);
    checkOutput("midrst_start", 32'(s_start), 32'd0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(AW'(i + 8'hC0), 2'b00, -1, -1, 1'b0, 1'b0);
    end
    checkOutput("txn_wrap", 32'(txn_cnt), 32'd0);

`ifdef FJ_TIMEOUT_EN
    applyStimulus(8'hE1, 2'b11, 2, -1, 1'b0, 1'b0);
    s_done = 2'b10;
    tick();
    s_done = '0;
    tick();
    @(negedge clk);
    checkOutput("late_done_busy", 32'(busy), 32'd0);
    checkOutput("late_done_txn", 32'(txn_cnt), 32'(exp_txn));
`endif

    checkOutput("start_q_drained", start_q.size(), 32'd0);
    checkOutput("ack_q_drained", ack_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
